led_pattern_seq: RTL and testbench
==================================

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 100000000, clk cycles per pattern step (1 s at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles before a button level is accepted (10 ms).
REQ-003 SHALL have port clk, input, 1, single 100 MHz system clock; all state on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn, input, 1, raw asynchronous push-button, active-high; requests the next mode.
REQ-006 SHALL have port en, input, 1, run enable; low freezes the step counter and pattern.
REQ-007 SHALL have port led, output, 3, registered LED drive, led[0] = LED1.
REQ-008 SHALL have port mode, output, 2, registered current mode.
REQ-009 SHALL have port step_tick, output, 1, one-cycle pulse on each pattern step.

Function
REQ-010 SHALL have a step counter that counts 0..STEP_CYCLES-1 while en=1, wraps to 0 and asserts step_tick for the cycle after it reaches STEP_CYCLES-1.
REQ-011 SHALL hold the step counter and led while en=0; step_tick SHALL be 0 while en=0.
REQ-012 SHALL update led only on steps; step latency: led changes on the same edge that registers step_tick=1.
REQ-013 SHALL implement mode 0 BLINK: 000 <-> 111 alternating; initial pattern 001 per REQ-018 is replaced by 111 at the first step, then 000, 111, ...
REQ-014 SHALL implement mode 1 CHASE: 001 -> 010 -> 100 -> 001 rotate-left; initial pattern 001.
REQ-015 SHALL implement mode 2 COUNT: binary increment modulo 8, 111 wraps to 000; initial pattern 000.
REQ-016 SHALL implement mode 3 ALT: 101 <-> 010; initial pattern 101.
REQ-017 SHALL pass btn through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any differing sample restarts the count.
REQ-018 SHALL, on a debounced 0->1 transition (press), advance mode by 1 modulo 4 (3 -> 0), load the new mode's initial pattern into led (mode 0 initial = 001), and clear the step counter, all on one edge; press acts regardless of en.
REQ-019 SHALL treat a press coinciding with a step as a press only: mode change wins, no pattern advance, step_tick=0 that cycle.
REQ-020 SHALL ignore the debounced 1->0 transition (release) and produce exactly one mode advance per accepted press.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force led=001, mode=00, step_tick=0, step counter=0, synchronizer flops=0, debounced level=0, debounce counter=0.
REQ-022 SHALL, on reset assertion mid-step or mid-debounce, discard all progress; after release a held btn SHALL need a full DEBOUNCE_CYCLES and SHALL then count as one press.
REQ-023 SHALL resume counting on the first posedge clk after rst_n deasserts (no extra wait state).

Structure
REQ-024 SHALL place mode encodings (MODE_BLINK=0, MODE_CHASE=1, MODE_COUNT=2, MODE_ALT=3) and per-mode initial-pattern constants in shared package led_seq_pkg.
REQ-025 SHALL implement synchronizer plus debouncer as sub-module btn_debounce (ports clk, rst_n, din, level, rise), instantiated once.
REQ-026 SHALL size the step counter as $clog2(STEP_CYCLES) bits and the debounce counter as $clog2(DEBOUNCE_CYCLES+1) bits.

Verification (STEP_CYCLES=10, DEBOUNCE_CYCLES=4)
REQ-027 SHALL verify reset/step: release rst_n, en=1, no btn -> step_tick every 10 cycles, led sequence 001, 111, 000, 111, mode=0.
REQ-028 SHALL verify debounce: btn glitches of 1-3 cycles -> no mode change; btn held 20 cycles -> mode goes 0 -> 1 exactly once, led=001, counter restarts (next step_tick 10 cycles later), then CHASE 010, 100, 001.
REQ-029 SHALL verify wrap: four clean presses from reset -> mode 1, 2, 3, 0; in mode 2 run 9 steps -> led 001...111, 000, 001 (wrap checked).
REQ-030 SHALL verify enable: en=0 for 25 cycles mid-step -> led, counter frozen, no step_tick; en=1 -> step arrives after the remaining cycles only.
REQ-031 SHALL verify collision: debounced press timed to the step cycle -> mode advances, led=new initial pattern, step_tick=0.
REQ-032 SHALL verify async reset: assert rst_n mid-debounce with btn held -> outputs at reset values immediately without a clock edge; after release exactly one press accepted after 4+2 cycles.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared mode encodings, per-mode initial patterns and the pattern-advance rule
// for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK = 2'd0,
        MODE_CHASE = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    localparam logic [2:0] INIT_BLINK = 3'b001;
    localparam logic [2:0] INIT_CHASE = 3'b001;
    localparam logic [2:0] INIT_COUNT = 3'b000;
    localparam logic [2:0] INIT_ALT   = 3'b101;

    function automatic logic [2:0] init_pattern(input mode_e m);
        logic [2:0] p;
        case (m)
            MODE_BLINK: p = INIT_BLINK;
            MODE_CHASE: p = INIT_CHASE;
            MODE_COUNT: p = INIT_COUNT;
            MODE_ALT:   p = INIT_ALT;
            default:    p = INIT_BLINK;
        endcase
        return p;
    endfunction

    // BLINK leaves any non-111 pattern (including its 001 start) for 111.
    function automatic logic [2:0] next_pattern(input mode_e m, input logic [2:0] cur);
        logic [2:0] p;
        case (m)
            MODE_BLINK: p = (cur == 3'b111) ? 3'b000 : 3'b111;
            MODE_CHASE: p = {cur[1:0], cur[2]};
            MODE_COUNT: p = cur + 3'd1;
            MODE_ALT:   p = (cur == 3'b101) ? 3'b010 : 3'b101;
            default:    p = cur;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_seq_btn_debounce.sv
// Two-flop synchronizer plus level debouncer for the mode push-button;
// rise flags the cycle on which a new high level is accepted.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive synchronized samples that differ from the accepted level.
    always_comb begin
        sync_d  = {sync_q[0], din};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == DEB_LAST) begin
            level_d = sync_q[1];
            cnt_d   = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer, debounced level and debounce counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_d & ~level_q;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps a 3-LED pattern once every STEP_CYCLES enabled
// cycles; each debounced button press selects the next of four patterns.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int STEP_CYCLES     = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       en,
    output logic [2:0] led,
    output logic [1:0] mode,
    output logic       step_tick
);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    logic          btn_level_s;
    logic          press_s;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [2:0]    led_q, led_d;
    mode_e         mode_q, mode_d;
    logic          tick_q, tick_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (btn),
        .level(btn_level_s),
        .rise (press_s)
    );

    // A press outranks a step falling on the same edge.
    always_comb begin
        cnt_d  = cnt_q;
        led_d  = led_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        if (press_s) begin
            mode_d = mode_e'(mode_q + 2'd1);
            led_d  = init_pattern(mode_e'(mode_q + 2'd1));
            cnt_d  = {SW{1'b0}};
        end else if (en) begin
            if (cnt_q == STEP_LAST) begin
                cnt_d  = {SW{1'b0}};
                tick_d = 1'b1;
                led_d  = next_pattern(mode_q, led_q);
            end else begin
                cnt_d = cnt_q + SW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Step counter, pattern, mode and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {SW{1'b0}};
            led_q  <= INIT_BLINK;
            mode_q <= MODE_BLINK;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
        end
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Randomized self-checking bench for led_pattern_seq against a cycle-level
// behavioural model built from run lengths and step phases.
module tb_led_pattern_seq;
    localparam int STEP = 10;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       en = 1'b0;
    logic [2:0] led;
    logic [1:0] mode;
    logic       step_tick;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int m_mode, m_led, m_tick, m_phase;
    int p1, p2, run_val, run_len, m_level;
    int presses_seen;
    int init_tab [4] = '{1, 1, 0, 5};

    led_pattern_seq #(
        .STEP_CYCLES    (STEP),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .en       (en),
        .led      (led),
        .mode     (mode),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int advance(input int md, input int cur);
        case (md)
            0:       return (cur == 7) ? 0 : 7;
            1:       return ((cur * 2) % 8) + ((cur >= 4) ? 1 : 0);
            2:       return (cur + 1) % 8;
            default: return cur ^ 7;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_led = 1; m_tick = 0; m_phase = 0;
        p1 = 0; p2 = 0; run_val = 0; run_len = 0; m_level = 0;
    endtask

    task automatic model_edge(input logic b, input logic e);
        int s;
        bit press;
        s = p2; p2 = p1; p1 = int'(b);
        if (s == run_val) run_len++;
        else begin run_val = s; run_len = 1; end
        press = 1'b0;
        if (run_len >= DEB && run_val != m_level) begin
            m_level = run_val;
            press = (run_val == 1);
        end
        m_tick = 0;
        if (press) begin
            presses_seen++;
            m_mode  = (m_mode + 1) % 4;
            m_led   = init_tab[m_mode];
            m_phase = 0;
        end else if (e) begin
            m_phase++;
            if (m_phase == STEP) begin
                m_phase = 0;
                m_tick  = 1;
                m_led   = advance(m_mode, m_led);
            end
        end
    endtask

    task automatic cycle(input logic b, input logic e);
        btn = b;
        en  = e;
        @(posedge clk);
        model_edge(b, e);
        @(negedge clk);
        check_eq("led", int'(led), m_led);
        check_eq("mode", int'(mode), m_mode);
        check_eq("step_tick", int'(step_tick), m_tick);
    endtask

    task automatic do_reset();
        btn = 1'b0;
        en  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_led", int'(led), 1);
        check_eq("rst_mode", int'(mode), 0);
        check_eq("rst_tick", int'(step_tick), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic repeat_cycles(input int n, input logic b, input logic e);
        for (int i = 0; i < n; i++) cycle(b, e);
    endtask

    initial begin
        int start_presses;
        presses_seen = 0;
        model_reset();
        @(negedge clk);

        // free-running BLINK
        do_reset();
        repeat_cycles(45, 1'b0, 1'b1);

        // glitches of 1..3 cycles, then a held press and CHASE steps
        for (int g = 1; g <= 3; g++) begin
            repeat_cycles(g, 1'b1, 1'b1);
            repeat_cycles(6, 1'b0, 1'b1);
        end
        check_eq("glitch_mode", int'(mode), 0);
        repeat_cycles(20, 1'b1, 1'b1);
        repeat_cycles(35, 1'b0, 1'b1);
        check_eq("press_mode", int'(mode), 1);

        // four presses and COUNT wrap
        do_reset();
        for (int p = 0; p < 4; p++) begin
            repeat_cycles(7, 1'b1, 1'b1);
            repeat_cycles(7, 1'b0, 1'b1);
            if (p == 1) repeat_cycles(STEP * 9 + 2, 1'b0, 1'b1);
        end
        check_eq("wrap_mode", int'(mode), 0);

        // enable freeze mid-step
        do_reset();
        repeat_cycles(4, 1'b0, 1'b1);
        repeat_cycles(25, 1'b0, 1'b0);
        repeat_cycles(20, 1'b0, 1'b1);

        // press lands on the step edge (rise at edge 20)
        do_reset();
        repeat_cycles(14, 1'b0, 1'b1);
        repeat_cycles(10, 1'b1, 1'b1);
        check_eq("collide_mode", int'(mode), 1);
        repeat_cycles(5, 1'b0, 1'b1);

        // randomized bursts on btn and en
        for (int k = 0; k < 300; k++) begin
            logic b;
            logic e;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++) begin
                e = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
                cycle(b, e);
            end
        end

        // async reset mid-debounce with btn held
        repeat_cycles(3, 1'b0, 1'b1);
        repeat_cycles(4, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_led", int'(led), 1);
        check_eq("async_mode", int'(mode), 0);
        check_eq("async_tick", int'(step_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        start_presses = presses_seen;
        repeat_cycles(5, 1'b1, 1'b1);
        check_eq("async_no_early", int'(mode), 0);
        repeat_cycles(15, 1'b1, 1'b1);
        check_eq("async_one_press", int'(mode), 1);
        check_eq("async_model_presses", presses_seen - start_presses, 1);
        repeat_cycles(10, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
